// File: rtl/video_in_pkg.sv
// Shared types and constants for the video capture write path.
package video_in_pkg;

  // Capture side: waiting for a frame, packing pixels, or draining the FIFO to RAM
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } cap_state_t;

  // Wishbone writer: no cycle open, or one write cycle waiting for ACK
  typedef enum logic {
    W_IDLE = 1'b0,
    W_BUS  = 1'b1
  } wr_state_t;

  localparam int         PIX_PER_WORD = 4;
  localparam int         WORD_W       = 8 * PIX_PER_WORD;
  localparam int         BYTE_CNT_W   = $clog2(PIX_PER_WORD);
  localparam logic [3:0] WB_SEL_ALL   = 4'hF;
  localparam int         CTR_EN_BIT   = 0;

endpackage

// File: rtl/video_in_wfifo.sv
// Word FIFO between the pixel packer and the Wishbone writer.
// First-word-fall-through: dout always shows the oldest entry while not empty.
// A push on a full FIFO is accepted when a pop happens in the same cycle.
module video_in_wfifo
  import video_in_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WORD_W-1:0] din,
  input  logic              pop,
  output logic [WORD_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_pop;
  logic              do_push;

  // Extra pointer bit distinguishes full from empty when the indices match
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; contents are discarded on reset by clearing both pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; no reset so it can map onto distributed RAM
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/video_in_write.sv
// Video capture to RAM: packs 8-bit pixels into 32-bit words (little-endian),
// buffers them in a word FIFO and writes them out as a Wishbone master.
// Optional feature macro: VIDEO_IN_IRQ_EN enables the end-of-frame interrupt;
// without it `interrupt` is tied low.
module video_in_write
  import video_in_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [31:0]       wb_reg_data,
  input  logic [31:0]       wb_reg_ctr,
  input  logic              pixel_en,
  input  logic              frame_valid,
  input  logic              line_valid,
  input  logic [7:0]        pixel_in,
  output logic              interrupt,
  output logic              overflow,
  output logic              p_wb_STB_O,
  output logic              p_wb_CYC_O,
  output logic              p_wb_WE_O,
  output logic              p_wb_LOCK_O,
  output logic [3:0]        p_wb_SEL_O,
  output logic [ADDR_W-1:0] p_wb_ADR_O,
  output logic [31:0]       p_wb_DAT_O,
  input  logic              p_wb_ACK_I
);

  cap_state_t          cap_state;
  wr_state_t           wr_state;
  logic                fv_d;
  logic                lv_d;
  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic [WORD_W-1:0]   word_reg;
  logic                push_reg;
  logic [WORD_W-1:0]   push_data;
  logic                overflow_reg;

  logic [ADDR_W-1:0]   addr_reg;
  logic [ADDR_W-1:0]   adr_reg;
  logic [WORD_W-1:0]   dat_reg;
  logic                bus_reg;
  logic [3:0]          sel_reg;

  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic [WORD_W-1:0]   fifo_dout;

  logic                fv_rise;
  logic                fv_fall;
  logic                lv_fall;
  logic                capture_en;
  logic                drain_pending;
  logic                frame_start;
  logic                drain_done;
  logic                pix_accept;
  logic                push_drop;
  logic [ADDR_W-1:0]   base_addr;
  logic                unused_bits;

  assign fv_rise    = frame_valid & ~fv_d;
  assign fv_fall    = ~frame_valid & fv_d;
  assign lv_fall    = ~line_valid & lv_d;
  assign capture_en = wb_reg_ctr[CTR_EN_BIT];
  assign base_addr  = ADDR_W'({wb_reg_data[31:2], 2'b00});

  // Anything still on its way to RAM: queued, in flight on the bus, or about to be pushed
  assign drain_pending = ~fifo_empty | (wr_state != W_IDLE) | push_reg;
  assign frame_start   = (cap_state == IDLE) & fv_rise & capture_en & ~drain_pending;
  assign drain_done    = (cap_state == DRAIN) & ~drain_pending;
  assign pix_accept    = (cap_state == CAPTURE) & pixel_en & frame_valid & line_valid;

  // Writer takes the head word whenever it is free; FWFT means no read latency
  assign fifo_pop  = (wr_state == W_IDLE) & ~fifo_empty;
  assign push_drop = push_reg & fifo_full & ~fifo_pop;

  assign unused_bits = ^{wb_reg_ctr[31:1], wb_reg_data[1:0]};

  video_in_wfifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (RST),
    .push  (push_reg),
    .din   (push_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Capture FSM with pixel packer, qualifier edge detection and overflow flag
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      cap_state    <= IDLE;
      fv_d         <= 1'b0;
      lv_d         <= 1'b0;
      byte_cnt     <= '0;
      word_reg     <= '0;
      push_reg     <= 1'b0;
      push_data    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      fv_d     <= frame_valid;
      lv_d     <= line_valid;
      push_reg <= 1'b0;
      if (push_drop) overflow_reg <= 1'b1;
      case (cap_state)
        IDLE: begin
          if (frame_start) begin
            cap_state    <= CAPTURE;
            overflow_reg <= 1'b0;
            byte_cnt     <= '0;
            word_reg     <= '0;
          end else if (fv_rise & capture_en & drain_pending) begin
            // Frame skipped because the previous one is still being written out
            overflow_reg <= 1'b1;
          end
        end
        CAPTURE: begin
          if (pix_accept) begin
            if (byte_cnt == BYTE_CNT_W'(PIX_PER_WORD - 1)) begin
              push_reg  <= 1'b1;
              push_data <= {pixel_in, word_reg[WORD_W-9:0]};
              word_reg  <= '0;
              byte_cnt  <= '0;
            end else begin
              word_reg[{byte_cnt, 3'b000} +: 8] <= pixel_in;
              byte_cnt <= byte_cnt + 1'b1;
            end
          end else if (lv_fall | fv_fall) begin
            // Line or frame end: flush a partial word; unused bytes are already zero
            if (byte_cnt != '0) begin
              push_reg  <= 1'b1;
              push_data <= word_reg;
            end
            word_reg <= '0;
            byte_cnt <= '0;
          end
          if (fv_fall) cap_state <= DRAIN;
        end
        DRAIN: begin
          if (fv_rise & capture_en) overflow_reg <= 1'b1;
          if (drain_done) cap_state <= IDLE;
        end
        default: cap_state <= IDLE;
      endcase
    end
  end

  // Writer FSM: one Wishbone write per word, outputs held until ACK
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      wr_state <= W_IDLE;
      addr_reg <= '0;
      adr_reg  <= '0;
      dat_reg  <= '0;
      bus_reg  <= 1'b0;
      sel_reg  <= 4'h0;
    end else begin
      sel_reg <= WB_SEL_ALL;
      // Safe to reload here: a frame only starts with the writer idle and the FIFO empty
      if (frame_start) addr_reg <= base_addr;
      case (wr_state)
        W_IDLE: begin
          if (~fifo_empty) begin
            wr_state <= W_BUS;
            adr_reg  <= addr_reg;
            dat_reg  <= fifo_dout;
            bus_reg  <= 1'b1;
          end
        end
        W_BUS: begin
          if (p_wb_ACK_I) begin
            wr_state <= W_IDLE;
            bus_reg  <= 1'b0;
            addr_reg <= addr_reg + ADDR_W'(4);
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  assign p_wb_STB_O  = bus_reg;
  assign p_wb_CYC_O  = bus_reg;
  assign p_wb_WE_O   = bus_reg;
  assign p_wb_LOCK_O = 1'b0;
  assign p_wb_SEL_O  = sel_reg;
  assign p_wb_ADR_O  = adr_reg;
  assign p_wb_DAT_O  = dat_reg;
  assign overflow    = overflow_reg;

`ifdef VIDEO_IN_IRQ_EN
  logic irq_reg;

  // One-cycle pulse when the last word of a frame has been acknowledged
  always_ff @(posedge clk or posedge RST) begin
    if (RST) irq_reg <= 1'b0;
    else     irq_reg <= drain_done;
  end

  assign interrupt = irq_reg;
`else
  assign interrupt = 1'b0;
`endif

endmodule

// File: tb/tb_video_in_write.sv
// Self-checking bench for video_in_write: random pixel frames against a packing model.
module tb_video_in_write;

  localparam int DEPTH = 16;
`ifdef VIDEO_IN_IRQ_EN
  localparam int IRQ_PER_FRAME = 1;
`else
  localparam int IRQ_PER_FRAME = 0;
`endif

  logic        clk = 1'b0;
  logic        RST;
  logic [31:0] wb_reg_data;
  logic [31:0] wb_reg_ctr;
  logic        pixel_en;
  logic        frame_valid;
  logic        line_valid;
  logic [7:0]  pixel_in;
  logic        interrupt;
  logic        overflow;
  logic        p_wb_STB_O, p_wb_CYC_O, p_wb_WE_O, p_wb_LOCK_O;
  logic [3:0]  p_wb_SEL_O;
  logic [31:0] p_wb_ADR_O;
  logic [31:0] p_wb_DAT_O;
  logic        p_wb_ACK_I;

  always #5 clk = ~clk;

  video_in_write #(.FIFO_DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .RST(RST), .wb_reg_data(wb_reg_data), .wb_reg_ctr(wb_reg_ctr),
    .pixel_en(pixel_en), .frame_valid(frame_valid), .line_valid(line_valid),
    .pixel_in(pixel_in), .interrupt(interrupt), .overflow(overflow),
    .p_wb_STB_O(p_wb_STB_O), .p_wb_CYC_O(p_wb_CYC_O), .p_wb_WE_O(p_wb_WE_O),
    .p_wb_LOCK_O(p_wb_LOCK_O), .p_wb_SEL_O(p_wb_SEL_O), .p_wb_ADR_O(p_wb_ADR_O),
    .p_wb_DAT_O(p_wb_DAT_O), .p_wb_ACK_I(p_wb_ACK_I)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] wr_adr_q[$];
  logic [31:0] wr_dat_q[$];
  logic [31:0] exp_adr[$];
  logic [31:0] exp_dat[$];
  logic [7:0]  pix_q[$];
  int          line_len_q[$];
  int          ack_delay = 0;
  int          ack_delay_once = 0;
  int          irq_cycles = 0;
  int          stab_err = 0;
  int          sel_err = 0;
  int          last_hold = 0;
  longint      cyc_cnt = 0;
  longint      last_ack_cyc = 0;
  longint      irq_cyc = 0;

  // Wishbone slave with programmable ACK latency; records every acknowledged write
  initial begin
    int waitc;
    int cur;
    logic [31:0] a0, d0;
    waitc = 0;
    a0 = '0;
    d0 = '0;
    p_wb_ACK_I = 1'b0;
    forever begin
      @(negedge clk);
      cyc_cnt++;
      if (interrupt === 1'b1) begin
        irq_cycles++;
        irq_cyc = cyc_cnt;
      end
      if (RST) begin
        p_wb_ACK_I = 1'b0;
        waitc = 0;
      end else if (p_wb_ACK_I) begin
        p_wb_ACK_I = 1'b0;
        waitc = 0;
      end else if (p_wb_STB_O && p_wb_CYC_O) begin
        if (waitc == 0) begin
          a0 = p_wb_ADR_O;
          d0 = p_wb_DAT_O;
        end else if (p_wb_ADR_O !== a0 || p_wb_DAT_O !== d0) begin
          stab_err++;
        end
        if (p_wb_SEL_O !== 4'hF || p_wb_LOCK_O !== 1'b0 || p_wb_WE_O !== 1'b1) sel_err++;
        cur = (ack_delay_once > 0) ? ack_delay_once : ack_delay;
        if (waitc >= cur) begin
          p_wb_ACK_I = 1'b1;
          wr_adr_q.push_back(p_wb_ADR_O);
          wr_dat_q.push_back(p_wb_DAT_O);
          last_ack_cyc = cyc_cnt;
          last_hold = waitc + 1;
          ack_delay_once = 0;
        end else begin
          waitc++;
        end
      end
    end
  end

  // Reference packing: each line chunked into 4-pixel words, little-endian, zero padded
  function automatic void build_expected(input logic [31:0] base);
    int idx;
    int n;
    logic [31:0] w;
    idx = 0;
    exp_adr.delete();
    exp_dat.delete();
    foreach (line_len_q[l]) begin
      for (int p = 0; p < line_len_q[l]; p += 4) begin
        w = '0;
        for (int b = 0; b < 4; b++)
          if (p + b < line_len_q[l]) w[8*b +: 8] = pix_q[idx + p + b];
        n = exp_dat.size();
        exp_dat.push_back(w);
        exp_adr.push_back({base[31:2], 2'b00} + 32'(4 * n));
      end
      idx += line_len_q[l];
    end
  endfunction

  task automatic new_case(input logic [31:0] base);
    wb_reg_data = base;
    wb_reg_ctr  = 32'h1;
    pix_q.delete();
    line_len_q.delete();
    wr_adr_q.delete();
    wr_dat_q.delete();
    irq_cycles = 0;
    stab_err = 0;
    sel_err = 0;
  endtask

  task automatic add_line(input int n, input logic [7:0] first, input bit rnd);
    line_len_q.push_back(n);
    for (int i = 0; i < n; i++) pix_q.push_back(rnd ? 8'($urandom) : first + 8'(i));
  endtask

  // Drives one frame from the queued lines; stray pixel_en between lines must be ignored
  task automatic drive_frame(input int period);
    int idx;
    idx = 0;
    @(negedge clk);
    frame_valid = 1'b1;
    repeat (3) @(negedge clk);
    foreach (line_len_q[l]) begin
      line_valid = 1'b1;
      for (int p = 0; p < line_len_q[l]; p++) begin
        pixel_in = pix_q[idx];
        idx++;
        pixel_en = 1'b1;
        @(negedge clk);
        pixel_en = 1'b0;
        pixel_in = 8'($urandom);
        repeat (period - 1) @(negedge clk);
      end
      line_valid = 1'b0;
      for (int g = 0; g < 4; g++) begin
        pixel_en = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      pixel_en = 1'b0;
    end
    frame_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    int quiet;
    int n;
    quiet = 0;
    n = 0;
    while (quiet < 30 && n < max_cyc) begin
      @(negedge clk);
      n++;
      if (p_wb_CYC_O) quiet = 0;
      else quiet++;
    end
    n_cmp++;
    if (quiet < 30) begin
      n_err++;
      $display("FAIL %s_timeout: bus busy after %0d cycles, required idle", tag, n);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({p_wb_STB_O, p_wb_CYC_O, p_wb_WE_O, p_wb_LOCK_O, p_wb_SEL_O, interrupt, overflow} !== 10'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got stb%b cyc%b we%b lock%b sel%h irq%b ovf%b, required all 0",
               p_wb_STB_O, p_wb_CYC_O, p_wb_WE_O, p_wb_LOCK_O, p_wb_SEL_O, interrupt, overflow);
    end
    n_cmp++;
    if (p_wb_ADR_O !== 32'h0 || p_wb_DAT_O !== 32'h0) begin
      n_err++;
      $display("FAIL reset_bus: got adr %h dat %h, required 0", p_wb_ADR_O, p_wb_DAT_O);
    end
    RST = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (p_wb_CYC_O !== 1'b0 || interrupt !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got cyc%b irq%b ovf%b, required 0", p_wb_CYC_O, interrupt, overflow);
    end
    $display("reset: done");
  endtask

  task automatic test_basic_frame();
    new_case(32'h0000_1000);
    add_line(8, 8'h00, 1'b0);
    add_line(8, 8'h08, 1'b0);
    build_expected(32'h0000_1000);
    drive_frame(4);
    wait_idle(2000, "basic");
    n_cmp++;
    if (wr_dat_q.size() != 4) begin
      n_err++;
      $display("FAIL basic_count: got %0d writes, required 4", wr_dat_q.size());
    end
    foreach (exp_dat[i]) if (i < wr_dat_q.size()) begin
      n_cmp++;
      if (wr_dat_q[i] !== exp_dat[i] || wr_adr_q[i] !== exp_adr[i]) begin
        n_err++;
        $display("FAIL basic_word%0d: got %h@%h, required %h@%h", i, wr_dat_q[i], wr_adr_q[i], exp_dat[i], exp_adr[i]);
      end
    end
    if (wr_dat_q.size() == 4) begin
      n_cmp++;
      if (wr_dat_q[0] !== 32'h0302_0100 || wr_adr_q[3] !== 32'h0000_100C || wr_dat_q[3] !== 32'h0F0E_0D0C) begin
        n_err++;
        $display("FAIL basic_literal: got first %h last %h@%h, required 03020100 0f0e0d0c@0000100c",
                 wr_dat_q[0], wr_dat_q[3], wr_adr_q[3]);
      end
    end
    n_cmp++;
    if (irq_cycles != IRQ_PER_FRAME || sel_err != 0) begin
      n_err++;
      $display("FAIL basic_irq: got %0d irq cycles (sel/lock errs %0d), required %0d", irq_cycles, sel_err, IRQ_PER_FRAME);
    end
`ifdef VIDEO_IN_IRQ_EN
    n_cmp++;
    if (irq_cyc <= last_ack_cyc) begin
      n_err++;
      $display("FAIL basic_irq_order: irq at cycle %0d, last ack at %0d, required irq after ack", irq_cyc, last_ack_cyc);
    end
`endif
    $display("basic_frame: %0d writes, %0d irq cycles", wr_dat_q.size(), irq_cycles);
  endtask

  task automatic test_partial_line();
    new_case(32'h0000_0800);
    add_line(6, 8'hA0, 1'b0);
    drive_frame(4);
    wait_idle(1000, "partial");
    n_cmp++;
    if (wr_dat_q.size() != 2) begin
      n_err++;
      $display("FAIL partial_count: got %0d writes, required 2", wr_dat_q.size());
    end else begin
      n_cmp++;
      if (wr_dat_q[0] !== 32'hA3A2_A1A0 || wr_dat_q[1] !== 32'h0000_A5A4 || wr_adr_q[1] !== 32'h0000_0804) begin
        n_err++;
        $display("FAIL partial_words: got %h %h@%h, required a3a2a1a0 0000a5a4@00000804",
                 wr_dat_q[0], wr_dat_q[1], wr_adr_q[1]);
      end
    end
    $display("partial_line: %0d writes", wr_dat_q.size());
  endtask

  task automatic test_random_frames();
    logic [31:0] base;
    for (int f = 0; f < 6; f++) begin
      base = (f == 5) ? 32'hFFFF_FFF9 : 32'($urandom);
      new_case(base);
      if (f == 5) add_line(12, 8'h40, 1'b0);
      else for (int l = 0; l < $urandom_range(1, 3); l++) add_line($urandom_range(1, 20), 8'h0, 1'b1);
      build_expected(base);
      ack_delay = $urandom_range(0, 1);
      drive_frame($urandom_range(2, 4));
      wait_idle(2000, "random");
      n_cmp++;
      if (wr_dat_q.size() != exp_dat.size()) begin
        n_err++;
        $display("FAIL rand%0d_count: got %0d writes, required %0d", f, wr_dat_q.size(), exp_dat.size());
      end
      foreach (exp_dat[i]) if (i < wr_dat_q.size()) begin
        n_cmp++;
        if (wr_dat_q[i] !== exp_dat[i] || wr_adr_q[i] !== exp_adr[i]) begin
          n_err++;
          $display("FAIL rand%0d_word%0d: got %h@%h, required %h@%h", f, i, wr_dat_q[i], wr_adr_q[i], exp_dat[i], exp_adr[i]);
        end
      end
      n_cmp++;
      if (irq_cycles != IRQ_PER_FRAME || overflow !== 1'b0) begin
        n_err++;
        $display("FAIL rand%0d_irq: got irq %0d ovf %b, required irq %0d ovf 0", f, irq_cycles, overflow, IRQ_PER_FRAME);
      end
      $display("random_frame %0d: base %h, %0d words", f, base, wr_dat_q.size());
    end
    ack_delay = 0;
  endtask

  task automatic test_disabled();
    new_case(32'h0000_5000);
    wb_reg_ctr = 32'h0;
    add_line(8, 8'h10, 1'b0);
    fork
      drive_frame(4);
      begin
        repeat (8) @(negedge clk);
        wb_reg_ctr = 32'h1;
      end
    join
    wait_idle(500, "disabled");
    n_cmp++;
    if (wr_dat_q.size() != 0 || irq_cycles != 0) begin
      n_err++;
      $display("FAIL disabled: got %0d writes %0d irq, required 0 and 0", wr_dat_q.size(), irq_cycles);
    end
    $display("disabled_frame: %0d writes", wr_dat_q.size());
  endtask

  task automatic test_overflow();
    new_case(32'h0000_2000);
    add_line(128, 8'h0, 1'b1);
    build_expected(32'h0000_2000);
    ack_delay_once = 200;
    drive_frame(1);
    wait_idle(3000, "overflow");
    n_cmp++;
    if (wr_dat_q.size() != DEPTH + 1) begin
      n_err++;
      $display("FAIL ovf_count: got %0d writes, required %0d", wr_dat_q.size(), DEPTH + 1);
    end
    foreach (wr_dat_q[i]) begin
      n_cmp++;
      if (wr_dat_q[i] !== exp_dat[i] || wr_adr_q[i] !== exp_adr[i]) begin
        n_err++;
        $display("FAIL ovf_word%0d: got %h@%h, required %h@%h", i, wr_dat_q[i], wr_adr_q[i], exp_dat[i], exp_adr[i]);
      end
    end
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_flag: got %b, required 1", overflow);
    end
    $display("overflow_frame: %0d writes, overflow %b", wr_dat_q.size(), overflow);
    new_case(32'h0000_2400);
    add_line(8, 8'h60, 1'b0);
    drive_frame(4);
    wait_idle(1000, "ovf_clear");
    n_cmp++;
    if (overflow !== 1'b0 || wr_dat_q.size() != 2) begin
      n_err++;
      $display("FAIL ovf_clear: got ovf %b writes %0d, required ovf 0 writes 2", overflow, wr_dat_q.size());
    end
    $display("overflow_clear: overflow %b", overflow);
  endtask

  task automatic test_ack_delay();
    new_case(32'h0000_6000);
    add_line(12, 8'h20, 1'b0);
    build_expected(32'h0000_6000);
    ack_delay = 5;
    drive_frame(4);
    wait_idle(2000, "ackdly");
    ack_delay = 0;
    n_cmp++;
    if (stab_err != 0 || last_hold != 6) begin
      n_err++;
      $display("FAIL ackdly_stable: got %0d unstable cycles, hold %0d, required 0 and 6", stab_err, last_hold);
    end
    n_cmp++;
    if (wr_dat_q.size() != 3) begin
      n_err++;
      $display("FAIL ackdly_count: got %0d writes, required 3", wr_dat_q.size());
    end
    foreach (exp_dat[i]) if (i < wr_dat_q.size()) begin
      n_cmp++;
      if (wr_dat_q[i] !== exp_dat[i] || wr_adr_q[i] !== exp_adr[i]) begin
        n_err++;
        $display("FAIL ackdly_word%0d: got %h@%h, required %h@%h", i, wr_dat_q[i], wr_adr_q[i], exp_dat[i], exp_adr[i]);
      end
    end
    $display("ack_delay: %0d writes, hold %0d", wr_dat_q.size(), last_hold);
  endtask

  task automatic test_reset_mid();
    int n;
    new_case(32'h0000_3000);
    add_line(8, 8'h30, 1'b0);
    ack_delay = 50;
    drive_frame(4);
    n = 0;
    while (p_wb_STB_O !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (p_wb_STB_O !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_stb: got stb %b after %0d cycles, required 1", p_wb_STB_O, n);
    end
    @(posedge clk);
    #2 RST = 1'b1;
    #1;
    n_cmp++;
    if ({p_wb_STB_O, p_wb_CYC_O, p_wb_WE_O, interrupt, overflow} !== 5'b0 || p_wb_ADR_O !== 32'h0 || p_wb_DAT_O !== 32'h0) begin
      n_err++;
      $display("FAIL rstmid_outputs: got stb%b cyc%b we%b irq%b ovf%b adr %h dat %h, required all 0",
               p_wb_STB_O, p_wb_CYC_O, p_wb_WE_O, interrupt, overflow, p_wb_ADR_O, p_wb_DAT_O);
    end
    repeat (3) @(negedge clk);
    RST = 1'b0;
    ack_delay = 0;
    repeat (60) @(negedge clk);
    n_cmp++;
    if (irq_cycles != 0 || wr_dat_q.size() != 0) begin
      n_err++;
      $display("FAIL rstmid_abort: got %0d irq %0d writes, required 0 and 0", irq_cycles, wr_dat_q.size());
    end
    new_case(32'h0000_4000);
    add_line(8, 8'h50, 1'b0);
    build_expected(32'h0000_4000);
    drive_frame(4);
    wait_idle(1000, "rstmid_after");
    n_cmp++;
    if (wr_dat_q.size() != 2) begin
      n_err++;
      $display("FAIL rstmid_count: got %0d writes, required 2", wr_dat_q.size());
    end else begin
      n_cmp++;
      if (wr_adr_q[0] !== exp_adr[0] || wr_dat_q[0] !== exp_dat[0] || wr_dat_q[1] !== exp_dat[1]) begin
        n_err++;
        $display("FAIL rstmid_after: got %h@%h %h, required %h@%h %h",
                 wr_dat_q[0], wr_adr_q[0], wr_dat_q[1], exp_dat[0], exp_adr[0], exp_dat[1]);
      end
    end
    $display("reset_mid: following frame %0d writes from %h", wr_dat_q.size(), wb_reg_data);
  endtask

  initial begin
    RST = 1'b1;
    wb_reg_data = '0;
    wb_reg_ctr = '0;
    pixel_en = 1'b0;
    frame_valid = 1'b0;
    line_valid = 1'b0;
    pixel_in = '0;
    test_reset();
    test_basic_frame();
    test_partial_line();
    test_random_frames();
    test_disabled();
    test_overflow();
    test_ack_delay();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
